// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: result entry layout and IRQ handshake states.
package alu_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    CLEAR = 2'd2
  } irq_state_t;

  typedef struct packed {
    logic  irq;
    data_t data;
  } alu_res_t;

  localparam int unsigned ALU_RES_W = $bits(alu_res_t);

endpackage

// File: rtl/alu_res_fifo.sv
// First-word-fall-through FIFO of ALU result entries; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [ALU_RES_W-1:0]       i_wdata,
  output logic [ALU_RES_W-1:0]       o_rdata,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ALU_RES_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic                 w_push;
  logic                 w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_count = r_count;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  // Head is gated so the read port reads zero whenever nothing is stored.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_result_collector.sv
// Collects valid ALU results with their IRQ tag into a FIFO and runs the host
// interrupt / ALU clear handshake with a bounded clear timeout.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CLR_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   alu_rst,
  input  logic [7:0]             alu_out,
  input  logic                   alu_irq,
  input  logic                   alu_res_vld,
  output logic                   alu_irq_clr,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   rd_irq_tag,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   host_irq,
  input  logic                   host_irq_ack,
  output logic                   clr_err,
  input  logic                   err_clr
);

  localparam int unsigned TmoW = $clog2(CLR_TIMEOUT) + 1;
  localparam logic [TmoW-1:0] TmoMax = TmoW'(CLR_TIMEOUT - 1);

  irq_state_t      r_state;
  logic [TmoW-1:0] r_tmo_cnt;
  logic            r_irq_prev;
  logic            r_host_irq;
  logic            r_irq_clr;
  logic            r_clr_err;
  logic            r_overflow;
  alu_res_t        w_wr_res;
  alu_res_t        w_rd_res;
  logic            w_full;
  logic            w_drop;

  assign w_wr_res = '{irq: alu_irq, data: alu_out};
  assign w_drop   = alu_res_vld && w_full && !rd_en;

  alu_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (alu_rst),
    .i_push  (alu_res_vld),
    .i_pop   (rd_en),
    .i_wdata (w_wr_res),
    .o_rdata (w_rd_res),
    .o_empty (empty),
    .o_full  (w_full),
    .o_count (count)
  );

  assign full        = w_full;
  assign rd_data     = w_rd_res.data;
  assign rd_irq_tag  = w_rd_res.irq;
  assign host_irq    = r_host_irq;
  assign alu_irq_clr = r_irq_clr;
  assign clr_err     = r_clr_err;
  assign overflow    = r_overflow;

  always_ff @(posedge clk or posedge alu_rst) begin
    if (alu_rst) begin
      r_state    <= IDLE;
      r_tmo_cnt  <= '0;
      r_irq_prev <= 1'b0;
      r_host_irq <= 1'b0;
      r_irq_clr  <= 1'b0;
      r_clr_err  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_irq_prev <= alu_irq;
      // Later assignments in this block override the clear, so a set event wins.
      if (err_clr) begin
        r_overflow <= 1'b0;
        r_clr_err  <= 1'b0;
      end
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        IDLE: begin
          if (alu_irq && !r_irq_prev) begin
            r_state    <= PEND;
            r_host_irq <= 1'b1;
          end
        end
        PEND: begin
          if (host_irq_ack) begin
            r_state    <= CLEAR;
            r_tmo_cnt  <= '0;
            r_host_irq <= 1'b0;
            r_irq_clr  <= 1'b1;
          end
        end
        CLEAR: begin
          if (!alu_irq) begin
            r_state   <= IDLE;
            r_irq_clr <= 1'b0;
          end else if (r_tmo_cnt == TmoMax) begin
            r_state   <= IDLE;
            r_irq_clr <= 1'b0;
            r_clr_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
          end
        end
        default: begin
          r_state    <= IDLE;
          r_host_irq <= 1'b0;
          r_irq_clr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench: stimulus queues expected FIFO entries, a monitor compares pops.
module tb_alu_result_collector;

  logic       clk = 1'b0;
  logic       alu_rst;
  logic [7:0] alu_out;
  logic       alu_irq;
  logic       alu_res_vld;
  logic       alu_irq_clr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_irq_tag;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic       host_irq;
  logic       host_irq_ack;
  logic       clr_err;
  logic       err_clr;

  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  alu_result_collector #(
    .DEPTH       (8),
    .CLR_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .alu_rst      (alu_rst),
    .alu_out      (alu_out),
    .alu_irq      (alu_irq),
    .alu_res_vld  (alu_res_vld),
    .alu_irq_clr  (alu_irq_clr),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_irq_tag   (rd_irq_tag),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .host_irq     (host_irq),
    .host_irq_ack (host_irq_ack),
    .clr_err      (clr_err),
    .err_clr      (err_clr)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic irq, input bit accept);
    alu_out     = d;
    alu_irq     = irq;
    alu_res_vld = 1'b1;
    if (accept) exp_q.push_back({irq, d});
    step();
    alu_res_vld = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic ack();
    host_irq_ack = 1'b1;
    step();
    host_irq_ack = 1'b0;
  endtask

  // Monitor: every accepted pop must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!alu_rst && rd_en && !empty) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 1, 0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("pop_data", int'(rd_data), int'(e[7:0]));
          check("pop_tag", int'(rd_irq_tag), int'(e[8]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    alu_rst = 1'b1; alu_out = 8'h00; alu_irq = 1'b0; alu_res_vld = 1'b0;
    rd_en = 1'b0; host_irq_ack = 1'b0; err_clr = 1'b0;
    #12;
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_count", int'(count), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_flags", int'({overflow, host_irq, alu_irq_clr, clr_err}), 0);
    step();
    alu_rst = 1'b0;
    step();

    // In-order FWFT traffic.
    push(8'h11, 1'b0, 1'b1);
    check("first_push_empty", int'(empty), 0);
    check("first_push_count", int'(count), 1);
    push(8'h22, 1'b0, 1'b1);
    push(8'h33, 1'b0, 1'b1);
    check("three_count", int'(count), 3);
    repeat (3) pop();
    check("drain_empty", int'(empty), 1);
    check("drain_count", int'(count), 0);
    pop();
    check("pop_empty_ignored", int'(overflow), 0);

    // Fill, overflow, then sticky clear.
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i), 1'b0, 1'b1);
    check("fill_full", int'(full), 1);
    check("fill_count", int'(count), 8);
    check("fill_no_ovf", int'(overflow), 0);
    push(8'h99, 1'b0, 1'b0);
    check("ovf_set", int'(overflow), 1);
    check("ovf_count", int'(count), 8);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovf_cleared", int'(overflow), 0);

    // Push and pop together while full.
    rd_en = 1'b1;
    push(8'hA5, 1'b0, 1'b1);
    rd_en = 1'b0;
    check("full_pp_count", int'(count), 8);
    check("full_pp_no_ovf", int'(overflow), 0);
    repeat (8) pop();
    check("full_drain_empty", int'(empty), 1);

    // Push and pop together while empty: only the push takes effect.
    rd_en = 1'b1;
    push(8'h5C, 1'b0, 1'b1);
    rd_en = 1'b0;
    check("empty_pp_count", int'(count), 1);
    pop();

    // IRQ handshake with a prompt clear.
    push(8'hFF, 1'b1, 1'b1);
    check("irq_host", int'(host_irq), 1);
    check("irq_no_clr", int'(alu_irq_clr), 0);
    ack();
    check("ack_clr", int'(alu_irq_clr), 1);
    check("ack_host_low", int'(host_irq), 0);
    step();
    step();
    check("clr_held", int'(alu_irq_clr), 1);
    alu_irq = 1'b0;
    step();
    check("clr_done", int'(alu_irq_clr), 0);
    check("clr_no_err", int'(clr_err), 0);
    pop();

    // Clear timeout: level stays high.
    alu_irq = 1'b1;
    step();
    check("tmo_host", int'(host_irq), 1);
    ack();
    n = 0;
    while (alu_irq_clr && n < 40) begin
      n++;
      step();
    end
    check("tmo_clr_cycles", n, 16);
    check("tmo_err", int'(clr_err), 1);
    repeat (4) step();
    check("tmo_no_retrigger", int'(host_irq), 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("tmo_err_cleared", int'(clr_err), 0);
    alu_irq = 1'b0;
    step();

    // Reset mid-CLEAR with stored entries.
    push(8'h01, 1'b0, 1'b1);
    push(8'h02, 1'b0, 1'b1);
    push(8'h03, 1'b0, 1'b1);
    alu_irq = 1'b1;
    step();
    ack();
    check("pre_rst_clr", int'(alu_irq_clr), 1);
    check("pre_rst_count", int'(count), 3);
    #2;
    alu_rst = 1'b1;
    #1;
    check("async_rst_clr", int'(alu_irq_clr), 0);
    check("async_rst_host", int'(host_irq), 0);
    check("async_rst_empty", int'(empty), 1);
    check("async_rst_count", int'(count), 0);
    exp_q.delete();
    alu_irq = 1'b0;
    step();
    alu_rst = 1'b0;
    step();
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
Downstream consumer of the dual-port ALU's outputs. It captures each valid alu_out byte, together with the alu_irq level sampled in the same cycle, into a first-word-fall-through (FWFT) FIFO that the host drains. It also runs the interrupt handshake: it raises host_irq on a new ALU interrupt, and after the host acknowledges, drives alu_irq_clr back to the ALU until alu_irq drops.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2.
CLR_TIMEOUT, 16, maximum cycles alu_irq_clr is held before declaring a clear failure.

Ports:
clk  in  1  system clock, rising edge.
alu_rst  in  1  reset, asynchronous, active-high.
alu_out  in  8  ALU result.
alu_irq  in  1  ALU interrupt level.
alu_res_vld  in  1  alu_out is valid this cycle; generated at top level.
alu_irq_clr  out  1  interrupt clear, driven to the ALU.
rd_en  in  1  host pop request.
rd_data  out  8  FIFO head data (FWFT).
rd_irq_tag  out  1  alu_irq value captured with the head entry.
empty  out  1  FIFO empty.
full  out  1  FIFO full.
count  out  $clog2(DEPTH)+1  number of occupied entries.
overflow  out  1  sticky flag: a result was dropped.
host_irq  out  1  interrupt to the host.
host_irq_ack  in  1  host acknowledge, single-cycle pulse.
clr_err  out  1  sticky flag: clear timed out.
err_clr  in  1  clears overflow and clr_err.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-high reset alu_rst.
- While alu_rst=1, asynchronously:
  - empty=1; full=0; count=0; rd_data=0; rd_irq_tag=0.
  - overflow=0; host_irq=0; alu_irq_clr=0; clr_err=0.
  - FSM in IDLE; FIFO pointers at 0.
  - Reset in the middle of a clear sequence drops alu_irq_clr immediately.
- FIFO push:
  - Accepted on a rising edge when alu_res_vld=1 and (full=0, or rd_en=1 in the same cycle).
  - Entry stored is {alu_irq, alu_out}, both sampled on that edge.
  - Push while full with no pop: data discarded, overflow set to 1 on the next edge.
- FIFO pop:
  - Occurs on a rising edge when rd_en=1 and empty=0.
  - rd_en while empty is ignored; no flag is raised.
  - Simultaneous push and pop when empty: push accepted, pop ignored, count becomes 1.
  - Simultaneous push and pop when full: both succeed, count unchanged.
- FIFO timing:
  - rd_data/rd_irq_tag show the head entry combinationally from storage.
  - The first push is visible the cycle after its edge (1-cycle latency to empty=0).
- FIFO counters:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - count is maintained separately; full = (count==DEPTH).
- Sticky flags: err_clr clears overflow and clr_err on the next edge. If a set event and err_clr coincide, the set wins.
- IRQ FSM states and transitions:
  - IDLE: alu_irq=1 with its previous sampled value 0 (rising edge) -> PEND. A level that was already high in IDLE does not re-trigger.
  - PEND: host_irq=1. host_irq_ack=1 -> CLEAR, and the timeout counter loads 0.
  - CLEAR: host_irq=0, alu_irq_clr=1, held for at least 1 cycle.
    - Stays in CLEAR while alu_irq=1 and counter < CLR_TIMEOUT-1; counter increments each cycle.
    - alu_irq=0 sampled in CLEAR -> IDLE; alu_irq_clr deasserts on that edge.
    - Counter reaching CLR_TIMEOUT-1 with alu_irq still 1 -> clr_err=1, then IDLE.
- host_irq_ack outside PEND is ignored.
- The IRQ FSM and the FIFO are independent; push continues in every FSM state.

Decomposition:
- alu_pkg additions:
  - typedef enum logic [1:0] irq_state_t {IDLE, PEND, CLEAR}.
  - typedef struct packed {logic irq; data_t data;} alu_res_t.
  - Constant ALU_RES_W = $bits(alu_res_t).
- Sub-module alu_res_fifo: parameterized FWFT FIFO of alu_res_t, providing push/pop/full/empty/count.
- The top level holds the IRQ FSM, the timeout counter and the sticky flags.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 with alu_irq=0, then pop 3 times -> rd_data reads 0x11, 0x22, 0x33 in order, rd_irq_tag=0, empty=1 and count=0 at the end.
- Push 9 results with DEPTH=8 and no pops -> full=1, count=8, overflow=1; the 9th value is absent; err_clr -> overflow=0.
- Full FIFO with push 0xA5 and pop in the same cycle -> count stays 8; the old head leaves; 0xA5 becomes the tail.
- alu_out=0xFF with alu_irq rising and vld=1 -> entry tag=1; host_irq=1 the next cycle; ack -> alu_irq_clr=1; TB drops alu_irq 2 cycles later -> FSM returns to IDLE, alu_irq_clr=0, clr_err=0.
- Ack, then alu_irq held high for 16 cycles -> alu_irq_clr high exactly 16 cycles, clr_err=1, FSM in IDLE, no new host_irq while the level stays high.
- Assert alu_rst mid-CLEAR with 3 entries stored -> alu_irq_clr=0 and host_irq=0 asynchronously, empty=1, count=0.
